ysyx_axi_sram: RTL and testbench
================================

YSYX_AXI_SRAM -- requirements
Module: ysyx_axi_sram

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DEPTH, default 1024, number of 64-bit memory words (power of two).
REQ-003 SHALL have parameter RD_LAT, default 2, cycles from AR handshake to first rvalid_o (legal range 1..15).
REQ-004 SHALL have ports, one per line: name direction width meaning, as follows.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 araddr  input  ADDR_W  read burst start byte address.
REQ-008 arlen  input  8  read beats minus one.
REQ-009 arid  input  4  read transaction ID.
REQ-010 arvalid  input  1  read address valid.
REQ-011 arready_o  output  1  read address accepted.
REQ-012 rid_o  output  4  ID of current read beat.
REQ-013 rdata_o  output  64  read data beat.
REQ-014 rresp_o  output  2  read response.
REQ-015 rlast_o  output  1  final read beat.
REQ-016 rvalid_o  output  1  read beat valid.
REQ-017 rready  input  1  master accepts read beat.
REQ-018 awaddr  input  ADDR_W  write burst start byte address.
REQ-019 awlen  input  8  write beats minus one.
REQ-020 awid  input  4  write transaction ID.
REQ-021 awvalid  input  1  write address valid.
REQ-022 awready_o  output  1  write address accepted.
REQ-023 wdata  input  64  write data beat.
REQ-024 wstrb  input  8  byte-lane enables, bit i = wdata[8i+7:8i].
REQ-025 wlast  input  1  master marks final write beat.
REQ-026 wvalid  input  1  write beat valid.
REQ-027 wready_o  output  1  write beat accepted.
REQ-028 bid_o  output  4  write response ID.
REQ-029 bresp_o  output  2  write response.
REQ-030 bvalid_o  output  1  write response valid.
REQ-031 bready  input  1  master accepts write response.

Function
REQ-032 Word index SHALL be addr[3+log2(DEPTH)-1:3]; addr[2:0] and bits above the index ignored (aliasing); bursts are INCR, 8 bytes/beat, index wrapping DEPTH-1 -> 0.
REQ-033 Read FSM SHALL be R_IDLE -> R_WAIT -> R_DATA -> R_IDLE; arready_o=1 only in R_IDLE; AR handshake latches index, arlen, arid.
REQ-034 In R_WAIT a counter SHALL run so rvalid_o first rises exactly RD_LAT cycles after the AR handshake cycle.
REQ-035 rdata_o SHALL be registered, loaded from memory when a beat is first presented, held stable with rvalid_o, rid_o, rlast_o until rvalid_o&rready.
REQ-036 On each R handshake, index and beat count SHALL increment; next beat presented the following cycle (no bubbles while rready=1); rlast_o=1 iff beat count == latched arlen.
REQ-037 After the last R handshake the FSM SHALL return to R_IDLE; arready_o=1 the next cycle (one-cycle turnaround).
REQ-038 Write FSM SHALL be W_IDLE -> W_DATA -> W_RESP -> W_IDLE; awready_o=1 only in W_IDLE, wready_o=1 only in W_DATA, bvalid_o=1 only in W_RESP.
REQ-039 Each W handshake SHALL update only byte lanes with wstrb set at the current index, then increment index; beat count == awlen moves FSM to W_RESP.
REQ-040 bresp_o SHALL be 2'b00 if wlast was 1 exactly on the final beat, else 2'b10 (SLVERR); burst length always governed by awlen; bid_o = latched awid.
REQ-041 bvalid_o SHALL hold until bready; W_RESP -> W_IDLE on handshake.
REQ-042 rresp_o SHALL always be 2'b00.
REQ-043 Read and write channels SHALL operate concurrently; a write committed in cycle t is visible to any read beat loaded at t+1 or later; a load in cycle t returns pre-write data.
REQ-044 Inputs wvalid in W_IDLE, and arvalid/awvalid outside idle, SHALL be ignored (not accepted, no state change).

Reset
REQ-045 On rst: both FSMs to idle, counters 0; arready_o=awready_o=1, rvalid_o=wready_o=bvalid_o=rlast_o=0, rdata_o=0, rid_o=bid_o=0, rresp_o=bresp_o=0; in-flight bursts aborted with no further beats; memory contents not cleared.

Verification
REQ-046 Write 0x1122334455667788 at 0x80000008 awlen=0 wstrb=FF wlast=1 -> bvalid_o with bresp 00, bid=awid; read same, RD_LAT=2 -> rvalid_o 2 cycles after AR, rdata match, rlast_o=1.
REQ-047 Partial write wstrb=0x0F data 0xAAAAAAAABBBBBBBB over word 0xFFFFFFFFFFFFFFFF -> read returns 0xFFFFFFFFBBBBBBBB.
REQ-048 Read burst arlen=3 from index DEPTH-2, rready toggled 1/0 -> 4 beats from DEPTH-2, DEPTH-1, 0, 1; data stable while stalled; rlast_o only on beat 4.
REQ-049 Write burst awlen=1 with wlast on first beat -> both beats written, bresp_o=2'b10; bready held 0 for 3 cycles -> bvalid_o held, awready_o stays 0.
REQ-050 Concurrent read burst and write burst to disjoint words, then rst asserted mid read burst -> rvalid_o=0 next cycle, arready_o=1, written data preserved.

Source files
------------

// File: rtl/ysyx_axi_sram.sv
// rtl/ysyx_axi_sram.sv - AXI-style burst SRAM slave with independent read and write channels
//
// Purpose: 64-bit wide, DEPTH-word SRAM behind AXI-like AR/R and AW/W/B channels.
//   INCR bursts of 8-byte beats. The word index wraps at DEPTH. Address bits
//   outside the index alias. Read data appears a fixed RD_LAT cycles after the
//   AR handshake. Reads and writes run concurrently.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   araddr/arlen/arid/arvalid     read address channel in, arready_o out
//   rid_o/rdata_o/rresp_o/rlast_o/rvalid_o, rready    read data channel
//   awaddr/awlen/awid/awvalid     write address channel in, awready_o out
//   wdata/wstrb/wlast/wvalid      write data channel in, wready_o out
//   bid_o/bresp_o/bvalid_o, bready                     write response channel
module ysyx_axi_sram #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] araddr,
  input  logic [7:0]        arlen,
  input  logic [3:0]        arid,
  input  logic              arvalid,
  output logic              arready_o,
  output logic [3:0]        rid_o,
  output logic [63:0]       rdata_o,
  output logic [1:0]        rresp_o,
  output logic              rlast_o,
  output logic              rvalid_o,
  input  logic              rready,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic [7:0]        awlen,
  input  logic [3:0]        awid,
  input  logic              awvalid,
  output logic              awready_o,
  input  logic [63:0]       wdata,
  input  logic [7:0]        wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready_o,
  output logic [3:0]        bid_o,
  output logic [1:0]        bresp_o,
  output logic              bvalid_o,
  input  logic              bready
);

  localparam int IDX_W = $clog2(DEPTH);
  // R_WAIT exits once the counter has covered the RD_LAT-1 idle cycles.
  localparam logic [3:0] WAIT_LAST = 4'(RD_LAT - 1);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

  logic [63:0] mem [DEPTH];

  r_state_e         r_state_q, r_state_d;
  logic [IDX_W-1:0] r_idx_q, r_idx_d;
  logic [7:0]       r_len_q, r_len_d;
  logic [7:0]       r_cnt_q, r_cnt_d;
  logic [3:0]       r_id_q, r_id_d;
  logic [3:0]       r_wait_q, r_wait_d;
  logic [63:0]      r_data_q, r_data_d;

  w_state_e         w_state_q, w_state_d;
  logic [IDX_W-1:0] w_idx_q, w_idx_d;
  logic [7:0]       w_len_q, w_len_d;
  logic [7:0]       w_cnt_q, w_cnt_d;
  logic [3:0]       w_id_q, w_id_d;
  logic             w_err_q, w_err_d;
  logic [1:0]       b_resp_q, b_resp_d;

  logic             r_load;
  logic [IDX_W-1:0] r_load_idx;
  logic             mem_we;
  logic             w_err_now;

  logic [IDX_W-1:0] ar_idx;
  logic [IDX_W-1:0] aw_idx;
  logic             unused_addr_bits;

  assign ar_idx = araddr[IDX_W+2:3];
  assign aw_idx = awaddr[IDX_W+2:3];
  assign unused_addr_bits = ^{araddr[2:0], awaddr[2:0],
                              araddr[ADDR_W-1:IDX_W+3], awaddr[ADDR_W-1:IDX_W+3]};

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      r_idx_q   <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_id_q    <= '0;
      r_wait_q  <= '0;
      r_data_q  <= '0;
      w_state_q <= W_IDLE;
      w_idx_q   <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_id_q    <= '0;
      w_err_q   <= 1'b0;
      b_resp_q  <= 2'b00;
    end else begin
      r_state_q <= r_state_d;
      r_idx_q   <= r_idx_d;
      r_len_q   <= r_len_d;
      r_cnt_q   <= r_cnt_d;
      r_id_q    <= r_id_d;
      r_wait_q  <= r_wait_d;
      r_data_q  <= r_data_d;
      w_state_q <= w_state_d;
      w_idx_q   <= w_idx_d;
      w_len_q   <= w_len_d;
      w_cnt_q   <= w_cnt_d;
      w_id_q    <= w_id_d;
      w_err_q   <= w_err_d;
      b_resp_q  <= b_resp_d;
    end
  end

  // Memory array is never reset; a beat arriving in a reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      for (int i = 0; i < 8; i++) begin
        if (wstrb[i]) mem[w_idx_q][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Read next-state
  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (arvalid) r_state_d = (RD_LAT == 1) ? R_DATA : R_WAIT;
      R_WAIT:  if (r_wait_q == WAIT_LAST) r_state_d = R_DATA;
      R_DATA:  if (rready && (r_cnt_q == r_len_q)) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read datapath: rdata is loaded on the edge that first presents each beat,
  // so a write committed on an earlier edge is always visible.
  always_comb begin
    r_idx_d    = r_idx_q;
    r_len_d    = r_len_q;
    r_cnt_d    = r_cnt_q;
    r_id_d     = r_id_q;
    r_wait_d   = r_wait_q;
    r_data_d   = r_data_q;
    r_load     = 1'b0;
    r_load_idx = r_idx_q;
    case (r_state_q)
      R_IDLE: begin
        if (arvalid) begin
          r_idx_d  = ar_idx;
          r_len_d  = arlen;
          r_id_d   = arid;
          r_cnt_d  = '0;
          r_wait_d = 4'd1;
          if (RD_LAT == 1) begin
            r_load     = 1'b1;
            r_load_idx = ar_idx;
          end
        end
      end
      R_WAIT: begin
        r_wait_d = r_wait_q + 4'd1;
        if (r_wait_q == WAIT_LAST) r_load = 1'b1;
      end
      R_DATA: begin
        if (rready && (r_cnt_q != r_len_q)) begin
          r_idx_d    = r_idx_q + IDX_W'(1);
          r_cnt_d    = r_cnt_q + 8'd1;
          r_load     = 1'b1;
          r_load_idx = r_idx_q + IDX_W'(1);
        end
      end
      default: ;
    endcase
    if (r_load) r_data_d = mem[r_load_idx];
  end

  // Read outputs
  always_comb begin
    arready_o = (r_state_q == R_IDLE);
    rvalid_o  = (r_state_q == R_DATA);
    rlast_o   = (r_state_q == R_DATA) && (r_cnt_q == r_len_q);
    rid_o     = r_id_q;
    rdata_o   = r_data_q;
    rresp_o   = 2'b00;
  end

  // Write next-state
  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (awvalid) w_state_d = W_DATA;
      W_DATA:  if (wvalid && (w_cnt_q == w_len_q)) w_state_d = W_RESP;
      W_RESP:  if (bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write datapath: a wlast that disagrees with the awlen-derived final beat
  // (early, late or missing) poisons the response; awlen always sets length.
  always_comb begin
    w_idx_d   = w_idx_q;
    w_len_d   = w_len_q;
    w_cnt_d   = w_cnt_q;
    w_id_d    = w_id_q;
    w_err_d   = w_err_q;
    b_resp_d  = b_resp_q;
    mem_we    = 1'b0;
    w_err_now = w_err_q | (wlast != (w_cnt_q == w_len_q));
    case (w_state_q)
      W_IDLE: begin
        if (awvalid) begin
          w_idx_d = aw_idx;
          w_len_d = awlen;
          w_id_d  = awid;
          w_cnt_d = '0;
          w_err_d = 1'b0;
        end
      end
      W_DATA: begin
        if (wvalid) begin
          mem_we  = 1'b1;
          w_idx_d = w_idx_q + IDX_W'(1);
          w_cnt_d = w_cnt_q + 8'd1;
          w_err_d = w_err_now;
          if (w_cnt_q == w_len_q) b_resp_d = w_err_now ? 2'b10 : 2'b00;
        end
      end
      default: ;
    endcase
  end

  // Write outputs
  always_comb begin
    awready_o = (w_state_q == W_IDLE);
    wready_o  = (w_state_q == W_DATA);
    bvalid_o  = (w_state_q == W_RESP);
    bid_o     = w_id_q;
    bresp_o   = b_resp_q;
  end

endmodule

// File: tb/tb_ysyx_axi_sram.sv
// tb/tb_ysyx_axi_sram.sv - directed plus randomized bench for ysyx_axi_sram against a word-array model
module tb_ysyx_axi_sram;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 1024;
  localparam int RD_LAT = 2;
  localparam int IDX_W  = $clog2(DEPTH);

  logic clk = 1'b0;
  logic rst;
  logic [ADDR_W-1:0] araddr, awaddr;
  logic [7:0] arlen, awlen, wstrb;
  logic [3:0] arid, awid, rid_o, bid_o;
  logic arvalid, arready_o, rlast_o, rvalid_o, rready;
  logic [63:0] rdata_o, wdata;
  logic [1:0] rresp_o, bresp_o;
  logic awvalid, awready_o, wlast, wvalid, wready_o, bvalid_o, bready;

  ysyx_axi_sram #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arlen(arlen), .arid(arid), .arvalid(arvalid), .arready_o(arready_o),
    .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o), .rlast_o(rlast_o),
    .rvalid_o(rvalid_o), .rready(rready),
    .awaddr(awaddr), .awlen(awlen), .awid(awid), .awvalid(awvalid), .awready_o(awready_o),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready_o(wready_o),
    .bid_o(bid_o), .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready(bready)
  );

  always #5 clk = ~clk;

  logic [63:0] ref_mem [DEPTH];
  logic [63:0] wd [256];
  logic [7:0]  ws [256];
  logic [3:0]  rid_val, wid_val;
  logic [63:0] last_rdata;
  bit          w_gaps;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] addr_of(input int idx);
    logic [31:0] a;
    a = $urandom;
    a[IDX_W+2:3] = idx[IDX_W-1:0];
    return a;
  endfunction

  task automatic fill_wd(input bit rand_strb);
    for (int i = 0; i < 256; i++) begin
      wd[i] = {$urandom, $urandom};
      ws[i] = rand_strb ? 8'($urandom) : 8'hFF;
    end
  endtask

  // Cycle engine: every negedge it observes outputs, updates the model for
  // handshakes about to happen on the next posedge, and drives new inputs.
  task automatic run(input bit do_rd, input logic [31:0] raddr, input int rlen, input int rpat,
                     input bit do_wr, input logic [31:0] waddr, input int wlen, input int wlast_at,
                     input int bhold, input int rst_beat);
    int rph, wph, rbeat, wbeat, hs_cyc, cyc, hold_left, ridx0, widx0, wi;
    bit first_seen, do_reset;
    logic [63:0] exp_d;
    rph = do_rd ? 0 : 3;
    wph = do_wr ? 0 : 3;
    rbeat = 0; wbeat = 0; hs_cyc = 0; cyc = 0; hold_left = bhold;
    first_seen = 0; do_reset = 0;
    ridx0 = int'(raddr[IDX_W+2:3]);
    widx0 = int'(waddr[IDX_W+2:3]);
    while (!(rph == 3 && wph == 3)) begin
      @(negedge clk);
      cyc++;
      if (cyc > 3000) begin
        total++; bad++;
        $error("FAIL timeout rph=%0d wph=%0d", rph, wph);
        arvalid = 0; awvalid = 0; wvalid = 0; rready = 0; bready = 0;
        break;
      end
      case (wph)
        0: begin
          awvalid = 1; awaddr = waddr; awlen = 8'(wlen); awid = wid_val;
          wvalid = 1; wdata = {$urandom, $urandom}; wstrb = 8'hFF; wlast = 1; bready = 0;
          if (awready_o) wph = 1;
        end
        1: begin
          awvalid = 1; awaddr = $urandom; awlen = 8'($urandom); awid = ~wid_val;
          chk("wready", wready_o, 1);
          wvalid = w_gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
          wdata = wd[wbeat]; wstrb = ws[wbeat]; wlast = (wbeat == wlast_at);
          if (wvalid) begin
            wi = (widx0 + wbeat) % DEPTH;
            for (int b = 0; b < 8; b++) if (wstrb[b]) ref_mem[wi][8*b +: 8] = wdata[8*b +: 8];
            wbeat++;
            if (wbeat > wlen) wph = 2;
          end
        end
        2: begin
          awvalid = 1; wvalid = 0;
          chk("bvalid", bvalid_o, 1);
          chk("bid", bid_o, wid_val);
          chk("bresp", bresp_o, (wlast_at == wlen) ? 2'b00 : 2'b10);
          chk("awready_busy", awready_o, 0);
          if (hold_left > 0) begin bready = 0; hold_left--; end
          else begin bready = 1; wph = 4; end
        end
        4: begin
          awvalid = 0; wvalid = 0; bready = 0;
          chk("bvalid_clear", bvalid_o, 0);
          chk("aw_turnaround", awready_o, 1);
          wph = 3;
        end
        default: ;
      endcase
      case (rph)
        0: begin
          arvalid = 1; araddr = raddr; arlen = 8'(rlen); arid = rid_val; rready = 0;
          if (arready_o) begin hs_cyc = cyc; rph = 1; end
        end
        1: begin
          arvalid = 1; araddr = $urandom; arlen = 8'($urandom); arid = ~rid_val;
          case (rpat)
            0: rready = 1;
            1: rready = (cyc % 2 == 0);
            default: rready = ($urandom_range(0, 1) == 1);
          endcase
          if (rvalid_o) begin
            if (!first_seen) begin
              chk("rd_latency", 64'(cyc - hs_cyc), 64'(RD_LAT));
              first_seen = 1;
            end
            exp_d = ref_mem[(ridx0 + rbeat) % DEPTH];
            chk("rdata", rdata_o, exp_d);
            chk("rid", rid_o, rid_val);
            chk("rlast", rlast_o, rbeat == rlen);
            chk("rresp", rresp_o, 2'b00);
            last_rdata = rdata_o;
            if (rbeat == rst_beat) do_reset = 1;
            else if (rready) begin
              rbeat++;
              if (rbeat > rlen) rph = 2;
            end
          end else if (first_seen) begin
            chk("rvalid_gap", rvalid_o, 1);
          end
        end
        2: begin
          arvalid = 0; rready = 0;
          chk("ar_turnaround", arready_o, 1);
          chk("rvalid_after_last", rvalid_o, 0);
          rph = 3;
        end
        default: ;
      endcase
      if (do_reset) begin
        rst = 1; arvalid = 0; awvalid = 0; wvalid = 0; rready = 0; bready = 0;
        @(negedge clk);
        chk("rst_rvalid", rvalid_o, 0);
        chk("rst_arready", arready_o, 1);
        chk("rst_awready", awready_o, 1);
        chk("rst_rlast", rlast_o, 0);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_rid", rid_o, 0);
        rst = 0;
        rph = 3; wph = 3;
      end
    end
  endtask

  initial begin
    int r0, w0, rl, wl, wla, base;
    rst = 1;
    araddr = 0; arlen = 0; arid = 0; arvalid = 0; rready = 0;
    awaddr = 0; awlen = 0; awid = 0; awvalid = 0;
    wdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 0;
    rid_val = 0; wid_val = 0; last_rdata = 0; w_gaps = 0;
    repeat (3) @(negedge clk);
    chk("reset_arready", arready_o, 1);
    chk("reset_awready", awready_o, 1);
    chk("reset_rvalid", rvalid_o, 0);
    chk("reset_wready", wready_o, 0);
    chk("reset_bvalid", bvalid_o, 0);
    chk("reset_rlast", rlast_o, 0);
    chk("reset_rdata", rdata_o, 0);
    chk("reset_ids", {rid_o, bid_o}, 0);
    chk("reset_resps", {rresp_o, bresp_o}, 0);
    rst = 0;

    // Fill the whole memory with 256-beat bursts through aliased addresses.
    w_gaps = 1;
    for (int k = 0; k < DEPTH / 256; k++) begin
      fill_wd(0);
      wid_val = 4'($urandom);
      run(0, 0, 0, 0, 1, addr_of(k * 256), 255, 255, 0, -1);
    end

    // Single full write then read back.
    w_gaps = 0;
    wd[0] = 64'h1122334455667788; ws[0] = 8'hFF; wid_val = 4'd5;
    run(0, 0, 0, 0, 1, 32'h80000008, 0, 0, 0, -1);
    rid_val = 4'd9;
    run(1, 32'h80000008, 0, 0, 0, 0, 0, 0, 0, -1);
    chk("single_rdata", last_rdata, 64'h1122334455667788);

    // Partial-strobe write over all-ones.
    wd[0] = 64'hFFFFFFFFFFFFFFFF; ws[0] = 8'hFF;
    run(0, 0, 0, 0, 1, addr_of(37), 0, 0, 0, -1);
    wd[0] = 64'hAAAAAAAABBBBBBBB; ws[0] = 8'h0F;
    run(0, 0, 0, 0, 1, addr_of(37), 0, 0, 0, -1);
    run(1, addr_of(37), 0, 0, 0, 0, 0, 0, 0, -1);
    chk("partial_rdata", last_rdata, 64'hFFFFFFFFBBBBBBBB);

    // Wrapping read burst with rready toggling.
    rid_val = 4'd3;
    run(1, addr_of(DEPTH - 2), 3, 1, 0, 0, 0, 0, 0, -1);

    // Early wlast: both beats still written, SLVERR, response held.
    fill_wd(0);
    wid_val = 4'd12;
    run(0, 0, 0, 0, 1, addr_of(200), 1, 0, 3, -1);
    run(1, addr_of(200), 1, 2, 0, 0, 0, 0, 0, -1);

    // Concurrent bursts, then reset in the middle of the read burst.
    fill_wd(1);
    rid_val = 4'd6; wid_val = 4'd10;
    run(1, addr_of(500), 15, 0, 1, addr_of(100), 3, 3, 0, 10);
    run(1, addr_of(100), 3, 0, 0, 0, 0, 0, 0, -1);

    // Randomized concurrent traffic on alternating disjoint halves.
    w_gaps = 1;
    for (int it = 0; it < 16; it++) begin
      fill_wd(1);
      rid_val = 4'($urandom); wid_val = 4'($urandom);
      rl = $urandom_range(0, 15); wl = $urandom_range(0, 15);
      base = (it % 2 == 0) ? 0 : DEPTH / 2;
      r0 = base + $urandom_range(0, DEPTH / 2 - 16);
      w0 = (DEPTH / 2 - base) + $urandom_range(0, DEPTH / 2 - 16);
      wla = ($urandom_range(0, 3) == 0) ? $urandom_range(0, wl + 1) - 1 : wl;
      run(1, addr_of(r0), rl, 2, 1, addr_of(w0), wl, wla, $urandom_range(0, 2), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
